// File: rtl/memoria_datos_param.sv
// memoria_datos_param
// Byte-addressed data memory with byte / halfword / word accesses,
// sign or zero extension on loads, alignment checking, a configurable
// number of wait states and a ready/busy handshake.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   EscrMem, LeerMem  store / load request (sampled only while idle)
//   outALU            byte address (wraps modulo the memory depth)
//   Datain            store data, right-aligned
//   Tamano            00 byte, 01 halfword, 10 word, 11 illegal
//   SinSigno          1 = zero-extend loads, 0 = sign-extend
//   Dataout           registered, extended load result
//   Ocupado           access in progress, new requests ignored
//   Listo             one-cycle completion pulse
//   ErrorAcc          one-cycle pulse for a rejected request
module memoria_datos_param #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0,
    parameter     INIT_FILE   = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EscrMem,
    input  logic              LeerMem,
    input  logic [ADDR_W+1:0] outALU,
    input  logic [DATA_W-1:0] Datain,
    input  logic [1:0]        Tamano,
    input  logic              SinSigno,
    output logic [DATA_W-1:0] Dataout,
    output logic              Ocupado,
    output logic              Listo,
    output logic              ErrorAcc
);

    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NUM_LANES = DATA_W / 8;
    // Counter preload; unused when there are no wait states.
    localparam logic [3:0] CNT_INI = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {REPOSO, ESPERA, FIN} estado_t;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    estado_t           estado_q, estado_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W+1:0] dir_q, dir_d;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic [1:0]        tam_q, tam_d;
    logic              sin_q, sin_d;
    logic              escr_q, escr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              listo_q, listo_d;
    logic              err_q, err_d;

    // Request classification
    logic pide, valido, alineado;
    always_comb begin
        alineado = 1'b1;
        case (Tamano)
            2'b01:   alineado = (outALU[0] == 1'b0);
            2'b10:   alineado = (outALU[1:0] == 2'b00);
            default: alineado = 1'b1;
        endcase
        pide   = EscrMem | LeerMem;
        valido = (EscrMem ^ LeerMem) && (Tamano != 2'b11) && alineado;
    end

    // Read path: lane extraction and extension from the latched operands
    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [DATA_W-1:0] palabra, rd_ext;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    assign idx     = dir_q[ADDR_W+1:2];
    assign off     = dir_q[1:0];
    assign palabra = mem[idx];

    always_comb begin
        rd_byte = palabra[8*off +: 8];
        rd_half = off[1] ? palabra[31:16] : palabra[15:0];
        case (tam_q)
            2'b00:   rd_ext = sin_q ? {{(DATA_W-8){1'b0}}, rd_byte}
                                    : {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = sin_q ? {{(DATA_W-16){1'b0}}, rd_half}
                                    : {{(DATA_W-16){rd_half[15]}}, rd_half};
            default: rd_ext = palabra;
        endcase
    end

    // Write path: replicate the right-aligned data across lanes and let
    // the byte enables pick the lanes that actually change.
    logic [NUM_LANES-1:0] be;
    logic [DATA_W-1:0]    wd;
    logic                 we;
    always_comb begin
        be = '0;
        wd = dato_q;
        case (tam_q)
            2'b00: begin
                be = 4'b0001 << off;
                wd = {4{dato_q[7:0]}};
            end
            2'b01: begin
                be = off[1] ? 4'b1100 : 4'b0011;
                wd = {2{dato_q[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = '0;
        endcase
        we = (estado_q == FIN) && escr_q;
    end

    // Array has no reset: contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NUM_LANES; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    // Next-state / output logic
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        dato_d   = dato_q;
        tam_d    = tam_q;
        sin_d    = sin_q;
        escr_d   = escr_q;
        dout_d   = dout_q;
        listo_d  = 1'b0;
        err_d    = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (pide) begin
                    if (valido) begin
                        dir_d    = outALU;
                        dato_d   = Datain;
                        tam_d    = Tamano;
                        sin_d    = SinSigno;
                        escr_d   = EscrMem;
                        cnt_d    = CNT_INI;
                        estado_d = (WAIT_CYCLES == 0) ? FIN : ESPERA;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ESPERA: begin
                if (cnt_q == 4'd0) estado_d = FIN;
                else               cnt_d    = cnt_q - 4'd1;
            end
            FIN: begin
                listo_d  = 1'b1;
                estado_d = REPOSO;
                if (!escr_q) dout_d = rd_ext;
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
            dir_q    <= '0;
            dato_q   <= '0;
            tam_q    <= '0;
            sin_q    <= 1'b0;
            escr_q   <= 1'b0;
            dout_q   <= '0;
            listo_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            dato_q   <= dato_d;
            tam_q    <= tam_d;
            sin_q    <= sin_d;
            escr_q   <= escr_d;
            dout_q   <= dout_d;
            listo_q  <= listo_d;
            err_q    <= err_d;
        end
    end

    assign Dataout  = dout_q;
    assign Ocupado  = (estado_q != REPOSO);
    assign Listo    = listo_q;
    assign ErrorAcc = err_q;

endmodule
